// File: rtl/priority_pkg.sv
// Shared state encoding, dwell-counter sizing and parameter legality for the priority_2 sequencer.
package priority_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_LAST   = 2'd2,
    ST_MIDDLE = 2'd3
  } state_t;

  // The counter must reach max(LAST_CYC, TMO_CYCLES) - 1; never narrower than one bit.
  function automatic int dwell_w(input int last_cyc, input int tmo_cycles);
    int m;
    m = 2;
    if (last_cyc > m) m = last_cyc;
    if (tmo_cycles > m) m = tmo_cycles;
    return $clog2(m);
  endfunction

  function automatic bit params_ok(input int sel_w, input int idle_code, input int last_code,
                                   input int last_cyc, input int tmo_cycles);
    return (sel_w >= 1) && (sel_w <= 30) && (idle_code != last_code) && (last_cyc >= 1) &&
           (tmo_cycles >= 0) && (idle_code >= 0) && (last_code >= 0) &&
           (idle_code < (1 << sel_w)) && (last_code < (1 << sel_w));
  endfunction

endpackage

// File: rtl/priority_dwell_cnt.sv
// Cycles-in-state counter: clear wins over increment, saturates at all-ones.
// Count visible one cycle after the clear/increment request.
module priority_dwell_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/priority_2.sv
// Handshake sequencer IDLE->RUN->MIDDLE->{LAST|IDLE} with LAST dwell and MIDDLE timeout.
// One-cycle input-to-state latency; f/busy/tmo are registered from the next state.
module priority_2
  import priority_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int IDLE_CODE  = 2,
  parameter int LAST_CODE  = 3,
  parameter int LAST_CYC   = 1,
  parameter int TMO_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             do_i,
  input  logic [SEL_W-1:0] sel,
  output logic             f,
  output logic             busy,
  output logic             tmo
);

  localparam int DW = dwell_w(LAST_CYC, TMO_CYCLES);
  localparam bit TMO_EN = (TMO_CYCLES != 0);
  localparam logic [SEL_W-1:0] IDLE_SEL = SEL_W'(IDLE_CODE);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST_CODE);
  localparam logic [DW-1:0] LAST_END = DW'(LAST_CYC - 1);
  localparam logic [DW-1:0] TMO_LAST = TMO_EN ? DW'(TMO_CYCLES - 1) : '0;

  if (!params_ok(SEL_W, IDLE_CODE, LAST_CODE, LAST_CYC, TMO_CYCLES)) begin : g_param_err
    $error("priority_2: illegal parameter combination");
  end

  state_t        state_q, state_d;
  logic          f_q, f_d;
  logic          busy_q, busy_d;
  logic          tmo_q, tmo_d;
  logic          dwell_clr;
  logic [DW-1:0] dwell;

  // Exit arms in MIDDLE are ordered: run request, idle code, last code, timeout.
  always_comb begin
    state_d = state_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (do_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!do_i) state_d = ST_MIDDLE;
      end
      ST_MIDDLE: begin
        if (do_i) begin
          state_d = ST_RUN;
        end else if (sel == IDLE_SEL) begin
          state_d = ST_IDLE;
        end else if (sel == LAST_SEL) begin
          state_d = ST_LAST;
        end else if (TMO_EN && (dwell == TMO_LAST)) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_LAST: begin
        if (dwell == LAST_END) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    f_d       = (state_d == ST_LAST);
    busy_d    = (state_d == ST_RUN) || (state_d == ST_MIDDLE);
    dwell_clr = (state_d != state_q);
  end

  priority_dwell_cnt #(
    .W(DW)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (dwell_clr),
    .inc  (!dwell_clr),
    .cnt  (dwell)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      f_q     <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign f    = f_q;
  assign busy = busy_q;
  assign tmo  = tmo_q;

  // ASCII state name for waveform viewers.
  function automatic logic [47:0] state_name(input state_t s);
    case (s)
      ST_IDLE:   return "IDLE  ";
      ST_RUN:    return "RUN   ";
      ST_LAST:   return "LAST  ";
      ST_MIDDLE: return "MIDDLE";
      default:   return "??????";
    endcase
  endfunction

endmodule

// File: tb/tb_priority_2.sv
// Three configurations of priority_2 driven side by side and compared every cycle
// against a cycles-in-state model plus directed duration/collision checks.
module tb_priority_2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] do_v;
  logic [3:0] sel_v [3];
  logic       f0, f1, f2, busy0, busy1, busy2, tmo0, tmo1, tmo2;

  priority_2 u0 (
    .clk(clk), .rst_n(rst_n), .do_i(do_v[0]), .sel(sel_v[0][1:0]),
    .f(f0), .busy(busy0), .tmo(tmo0)
  );

  priority_2 #(.LAST_CYC(4)) u1 (
    .clk(clk), .rst_n(rst_n), .do_i(do_v[1]), .sel(sel_v[1][1:0]),
    .f(f1), .busy(busy1), .tmo(tmo1)
  );

  priority_2 #(.SEL_W(4), .IDLE_CODE(9), .LAST_CODE(5), .TMO_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .do_i(do_v[2]), .sel(sel_v[2]),
    .f(f2), .busy(busy2), .tmo(tmo2)
  );

  int c_lc   [3] = '{1, 4, 1};
  int c_tmo  [3] = '{16, 16, 0};
  int c_ic   [3] = '{2, 2, 9};
  int c_lcode[3] = '{3, 3, 5};

  // Model: 0=IDLE 1=RUN 2=LAST 3=MIDDLE; m_t = cycles already spent in the state.
  int m_st [3];
  int m_t  [3];
  bit m_f  [3];
  bit m_busy [3];
  bit m_tmo  [3];

  int cnt_f [3];
  int cnt_busy [3];
  int cnt_tmo [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic obs_f(input int i);
    case (i)
      0: return f0;
      1: return f1;
      default: return f2;
    endcase
  endfunction

  function automatic logic obs_busy(input int i);
    case (i)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic obs_tmo(input int i);
    case (i)
      0: return tmo0;
      1: return tmo1;
      default: return tmo2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_t[i] = 0; m_f[i] = 0; m_busy[i] = 0; m_tmo[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit d, input int s);
    int  nx;
    bit  to;
    nx = m_st[i];
    to = 0;
    if (m_st[i] == 0) begin
      if (d) nx = 1;
    end else if (m_st[i] == 1) begin
      if (!d) nx = 3;
    end else if (m_st[i] == 2) begin
      // this edge ends the LAST_CYC-th cycle of LAST
      if (m_t[i] + 1 == c_lc[i]) nx = 0;
    end else begin
      if (d) nx = 1;
      else if (s == c_ic[i]) nx = 0;
      else if (s == c_lcode[i]) nx = 2;
      else if (c_tmo[i] != 0 && m_t[i] + 1 == c_tmo[i]) begin
        nx = 0;
        to = 1;
      end
    end
    m_t[i]    = (nx == m_st[i]) ? m_t[i] + 1 : 0;
    m_st[i]   = nx;
    m_f[i]    = (nx == 2);
    m_busy[i] = (nx == 1) || (nx == 3);
    m_tmo[i]  = to;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d.f", i), 32'(obs_f(i)), 32'(m_f[i]));
      check_eq($sformatf("u%0d.busy", i), 32'(obs_busy(i)), 32'(m_busy[i]));
      check_eq($sformatf("u%0d.tmo", i), 32'(obs_tmo(i)), 32'(m_tmo[i]));
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      cnt_f[i] = 0; cnt_busy[i] = 0; cnt_tmo[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst_n) model_step(i, do_v[i], int'(sel_v[i]));
    end
    if (!rst_n) model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) begin
      cnt_f[i]    += int'(obs_f(i));
      cnt_busy[i] += int'(obs_busy(i));
      cnt_tmo[i]  += int'(obs_tmo(i));
    end
    @(negedge clk);
  endtask

  task automatic set_all(input logic [2:0] d, input int s01, input int s2);
    do_v     = d;
    sel_v[0] = 4'(s01);
    sel_v[1] = 4'(s01);
    sel_v[2] = 4'(s2);
  endtask

  initial begin
    rst_n = 1'b0;
    set_all(3'b000, 0, 0);
    model_reset();
    clear_counts();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Basic pass through LAST; u1 sees `do` toggling while in LAST.
    clear_counts();
    set_all(3'b111, 0, 0);  tick();
    set_all(3'b000, 3, 5);  tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      do_v[1] = k[0] ? 1'b0 : 1'b1;
      tick();
    end
    do_v[1] = 1'b0;
    tick(); tick();
    check_eq("dflt_f_len", 32'(cnt_f[0]), 32'd1);
    check_eq("dflt_busy_len", 32'(cnt_busy[0]), 32'd2);
    check_eq("dflt_tmo_cnt", 32'(cnt_tmo[0]), 32'd0);
    check_eq("last4_f_len", 32'(cnt_f[1]), 32'd4);
    check_eq("w4_f_len", 32'(cnt_f[2]), 32'd1);

    // MIDDLE timeout with no exit selected.
    clear_counts();
    set_all(3'b111, 0, 0);  tick();
    set_all(3'b000, 0, 0);
    repeat (20) tick();
    check_eq("tmo_pulses", 32'(cnt_tmo[0]), 32'd1);
    check_eq("tmo_busy_len", 32'(cnt_busy[0]), 32'd17);
    check_eq("notmo_busy", 32'(busy2), 32'd1);
    set_all(3'b000, 0, 9);  tick();

    // Collisions on the timeout cycle: do, idle code, last code.
    for (int k = 0; k < 3; k++) begin
      set_all(3'b111, 0, 9);  tick();
      set_all(3'b000, 0, 9);  tick();
      repeat (15) tick();
      if (k == 0) set_all(3'b111, 0, 9);
      else if (k == 1) set_all(3'b000, 2, 9);
      else set_all(3'b000, 3, 9);
      tick();
      check_eq($sformatf("coll%0d_tmo", k), 32'(tmo0), 32'd0);
      check_eq($sformatf("coll%0d_busy", k), 32'(busy0), (k == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("coll%0d_f", k), 32'(f0), (k == 2) ? 32'd1 : 32'd0);
      set_all(3'b000, 2, 9);
      repeat (6) tick();
    end

    // Non-code selects hold MIDDLE forever when the timeout is disabled.
    set_all(3'b111, 2, 9);  tick();
    set_all(3'b000, 2, 2);  tick();
    clear_counts();
    for (int k = 0; k < 100; k++) begin
      sel_v[2] = k[0] ? 4'd3 : 4'd2;
      tick();
    end
    check_eq("w4_hold_busy", 32'(cnt_busy[2]), 32'd100);
    check_eq("w4_hold_tmo", 32'(cnt_tmo[2]), 32'd0);
    sel_v[2] = 4'd5;  tick();
    check_eq("w4_last_f", 32'(f2), 32'd1);
    sel_v[2] = 4'd0;  tick();
    set_all(3'b111, 2, 0);  tick();
    set_all(3'b000, 2, 0);  tick();
    sel_v[2] = 4'd9;  tick();
    check_eq("w4_idle_busy", 32'(busy2), 32'd0);
    check_eq("w4_idle_f", 32'(f2), 32'd0);

    // Asynchronous reset two cycles into LAST of u1.
    set_all(3'b111, 0, 9);  tick();
    set_all(3'b000, 3, 5);  tick();
    tick(); tick(); tick();
    check_eq("pre_rst_f1", 32'(f1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("async_rst_f1", 32'(f1), 32'd0);
    #1 rst_n = 1'b1;
    set_all(3'b000, 0, 0);
    tick();
    set_all(3'b111, 0, 0);  tick();
    check_eq("post_rst_busy1", 32'(busy1), 32'd1);
    set_all(3'b000, 2, 9);
    repeat (3) tick();

    // Randomised run; inputs change sporadically so long dwells and timeouts occur.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          do_v[i] = ($urandom_range(0, 7) == 0);
          if (i < 2) sel_v[i] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 1));
          else if ($urandom_range(0, 5) == 0) sel_v[i] = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'd9;
          else sel_v[i] = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/priority_2.md
Name: priority_2

Overview:
- Parametrised successor of the fixed 4-state priority FSM (IDLE/RUN/MIDDLE/LAST) with registered on-state outputs.
- Adds configurable select width and codes, a multi-cycle LAST dwell, a MIDDLE-state timeout with error pulse, and a busy flag.
- Sits in the bench/control layer as a generic handshake sequencer driven by `do` and a select code.

Parameters:
- SEL_W, 2, width of `sel`.
- IDLE_CODE, 2, `sel` value that sends MIDDLE back to IDLE.
- LAST_CODE, 3, `sel` value that sends MIDDLE to LAST; must differ from IDLE_CODE.
- LAST_CYC, 1, number of cycles spent in LAST; must be >= 1. A value of 1 reproduces the single-cycle LAST.
- TMO_CYCLES, 16, maximum cycles in MIDDLE before a forced return to IDLE; 0 disables the timeout.

Ports:
- clk  input  1  clock; all flops on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- do  input  1  run request.
- sel  input  SEL_W  exit select, sampled only in MIDDLE.
- f  output  1  registered; high exactly while state==LAST.
- busy  output  1  registered; high while state is RUN or MIDDLE.
- tmo  output  1  registered; one-cycle pulse on the first IDLE cycle after a timeout exit.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, dwell counter=0, f=busy=tmo=0. Reset mid-operation aborts immediately to these values; no pending pulse survives.
- State encoding: 2-bit, IDLE=0, RUN=1, LAST=2, MIDDLE=3. Illegal state goes to IDLE (unreachable with 2-bit encoding, but the default arm is required).
- IDLE: do=1 -> RUN; otherwise hold.
- RUN: do=0 -> MIDDLE; otherwise hold.
- MIDDLE, strict priority:
  1. do=1 -> RUN
  2. sel==IDLE_CODE -> IDLE
  3. sel==LAST_CODE -> LAST
  4. TMO_CYCLES!=0 and dwell==TMO_CYCLES-1 -> IDLE with tmo
  5. otherwise hold.
- LAST: dwell==LAST_CYC-1 -> IDLE; otherwise hold. `do` and `sel` are ignored in LAST.
- Dwell counter:
  - Single shared counter, width $clog2(max(LAST_CYC,TMO_CYCLES,2)).
  - Cleared whenever nextstate != state; incremented whenever the state holds; saturates at max.
  - Counts cycles already spent in the current state, starting at 0 on the first cycle.
- Outputs are computed from nextstate and registered, so each output aligns with the state it describes:
  - f <= (nextstate==LAST)
  - busy <= (nextstate==RUN || nextstate==MIDDLE)
  - tmo <= 1 only when the transition taken is the timeout arm; otherwise 0.
- Simultaneous events in MIDDLE resolve by the priority order above:
  - do=1 on the timeout cycle -> RUN, tmo=0.
  - sel==IDLE_CODE on the timeout cycle -> IDLE, tmo=0 (the exit is normal, not a timeout).
- Durations:
  - MIDDLE lasts exactly TMO_CYCLES cycles when no exit is taken.
  - LAST always lasts exactly LAST_CYC cycles.
- Latency: one cycle from input to state change; outputs change on the same edge as state.

Decomposition:
- Package priority_pkg holds:
  - the state encoding constants (IDLE/RUN/LAST/MIDDLE, 2-bit state type),
  - a clog2-based counter-width helper,
  - a parameter-legality check (IDLE_CODE!=LAST_CODE, LAST_CYC>=1, codes < 2**SEL_W).
- One sub-module, priority_dwell_cnt (parametrised width; clear, increment, saturate, count out), instantiated once.
- Next-state logic, output registers and the simulation state-name decode stay in priority_2.

Test Plan:
- Defaults. Reset, then do=1 for 1 cycle, do=0, sel=3 -> state IDLE->RUN->MIDDLE->LAST->IDLE; f=1 for exactly 1 cycle; busy=1 for 2 cycles; tmo never asserts.
- LAST_CYC=4. Same stimulus -> f high for exactly 4 consecutive cycles, then IDLE; toggling `do` during LAST has no effect.
- TMO_CYCLES=16, sel=0, do=0 in MIDDLE -> MIDDLE held for 16 cycles, then IDLE; tmo=1 for one cycle, coincident with the first IDLE cycle; busy drops on the same edge.
- Timeout cycle (MIDDLE dwell=15), collision cases:
  - do=1 -> RUN, tmo=0.
  - Repeat with sel=2 -> IDLE, tmo=0.
  - Repeat with sel=3 -> LAST, tmo=0.
- SEL_W=4, IDLE_CODE=9, LAST_CODE=5, TMO_CYCLES=0:
  - sel=2 or 3 in MIDDLE holds indefinitely (e.g. 100 cycles, no tmo).
  - sel=5 -> LAST.
  - sel=9 -> IDLE.
- rst_n asserted asynchronously mid-LAST (LAST_CYC=4, dwell=2) -> f, busy, tmo and state go to 0/IDLE immediately, without waiting for a clock edge; after release, do=1 -> RUN on the next edge.
